// File: rtl/mdio_master.sv
// MDIO (Clause 22/45) master: serialises one PHY register access per request onto MDC/MDIO.
// Latency: o_valid (PREAMBLE_LEN+33)*2*CLK_DIV cycles after accept; illegal ops complete next cycle.
// Backpressure: o_stall high while a frame runs; strobes seen during stall are dropped, never queued.
module mdio_master #(
    parameter int CLK_DIV      = 50,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic        i_c45,
    input  logic [1:0]  i_op,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_data,
    output logic        o_stall,
    output logic        o_valid,
    output logic        o_err,
    output logic [15:0] o_data,
    output logic        enet_mdc,
    output logic        enet_mdio_en,
    output logic        enet_o_mdio,
    input  logic        enet_i_mdio
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_END
    } state_t;

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [4:0]       PRE_LOAD = (PREAMBLE_LEN > 0) ? 5'(PREAMBLE_LEN - 1) : 5'd0;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              mdc_q, mdc_d;
    logic              en_q, en_d;
    logic              out_q, out_d;
    logic [31:0]       tx_q, tx_d;
    logic [15:0]       rx_q, rx_d;
    logic              rd_q, rd_d;
    logic              ta_err_q, ta_err_d;
    logic              stall_q, stall_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [15:0]       data_q, data_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;

    logic              tick;
    logic              req_illegal;
    logic [31:0]       req_frame;

    assign tick        = (div_q == '0);
    assign req_illegal = !i_c45 && ((i_op == 2'b00) || (i_op == 2'b11));
    // Everything after the preamble: ST, OP, PHYAD, REG/DEVAD, TA(10), DATA.
    assign req_frame   = {(i_c45 ? 2'b00 : 2'b01), i_op, i_phy_addr, i_reg_addr, 2'b10, i_data};

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        mdc_d    = mdc_q;
        en_d     = en_q;
        out_d    = out_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rd_d     = rd_q;
        ta_err_d = ta_err_q;
        stall_d  = stall_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        data_d   = data_q;
        sync1_d  = enet_i_mdio;
        sync2_d  = sync1_q;

        if (state_q == ST_IDLE) begin
            if (i_stb && !stall_q) begin
                if (req_illegal) begin
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    stall_d  = 1'b1;
                    rd_d     = i_op[1];
                    ta_err_d = 1'b0;
                    div_d    = DIV_LOAD;
                    mdc_d    = 1'b0;
                    en_d     = 1'b1;
                    if (PREAMBLE_LEN > 0) begin
                        state_d = ST_PRE;
                        cnt_d   = PRE_LOAD;
                        out_d   = 1'b1;
                        tx_d    = req_frame;
                    end else begin
                        state_d = ST_HDR;
                        cnt_d   = 5'd13;
                        out_d   = req_frame[31];
                        tx_d    = {req_frame[30:0], 1'b0};
                    end
                end
            end
        end else if (state_q == ST_END && mdc_q && div_q == DIV_ONE) begin
            // Finish one cycle early so o_valid lands where the next frame's accept can start.
            state_d = ST_IDLE;
            div_d   = DIV_LOAD;
            mdc_d   = 1'b0;
            stall_d = 1'b0;
            valid_d = 1'b1;
            err_d   = rd_q & ta_err_q;
            if (rd_q) begin
                data_d = rx_q;
            end
        end else begin
            div_d = tick ? DIV_LOAD : div_q - DIV_ONE;
            if (tick && !mdc_q) begin
                mdc_d = 1'b1;
                if (state_q == ST_TA && cnt_q == 5'd0 && rd_q) begin
                    ta_err_d = sync2_q;
                end
                if (state_q == ST_DATA) begin
                    rx_d = {rx_q[14:0], sync2_q};
                end
            end else if (tick && mdc_q) begin
                mdc_d = 1'b0;
                cnt_d = cnt_q - 5'd1;
                out_d = tx_q[31];
                tx_d  = {tx_q[30:0], 1'b0};
                case (state_q)
                    ST_PRE: begin
                        if (cnt_q == 5'd0) begin
                            state_d = ST_HDR;
                            cnt_d   = 5'd13;
                        end else begin
                            out_d = 1'b1;
                            tx_d  = tx_q;
                        end
                    end
                    ST_HDR: begin
                        if (cnt_q == 5'd0) begin
                            state_d = ST_TA;
                            cnt_d   = 5'd1;
                            en_d    = !rd_q;
                        end
                    end
                    ST_TA: begin
                        if (cnt_q == 5'd0) begin
                            state_d = ST_DATA;
                            cnt_d   = 5'd15;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q == 5'd0) begin
                            state_d = ST_END;
                            cnt_d   = 5'd0;
                            en_d    = 1'b0;
                            out_d   = 1'b1;
                            tx_d    = tx_q;
                        end
                    end
                    default: begin
                        cnt_d = cnt_q;
                        out_d = out_q;
                        tx_d  = tx_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            div_q    <= DIV_LOAD;
            cnt_q    <= 5'd0;
            mdc_q    <= 1'b0;
            en_q     <= 1'b0;
            out_q    <= 1'b1;
            tx_q     <= 32'd0;
            rx_q     <= 16'd0;
            rd_q     <= 1'b0;
            ta_err_q <= 1'b0;
            stall_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= 16'd0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            mdc_q    <= mdc_d;
            en_q     <= en_d;
            out_q    <= out_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rd_q     <= rd_d;
            ta_err_q <= ta_err_d;
            stall_q  <= stall_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            data_q   <= data_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    assign o_stall      = stall_q;
    assign o_valid      = valid_q;
    assign o_err        = err_q;
    assign o_data       = data_q;
    assign enet_mdc     = mdc_q;
    assign enet_mdio_en = en_q;
    assign enet_o_mdio  = out_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: instance A (CLK_DIV=2, PREAMBLE_LEN=32) and B (CLK_DIV=2, PREAMBLE_LEN=0),
// each with a simple PHY model that answers reads on MDIO.
module tb_mdio_master;

    typedef struct {
        logic        inst;
        logic        c45;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wdat;
        logic        phy_on;
        logic [15:0] phy_dat;
        logic        mid_stb;
        int          exp_lat;
        int          exp_bits;
        logic [31:0] exp_frame;
        logic [31:0] exp_mask;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  stb = 2'b00;
    logic        c45 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [4:0]  phy = 5'd0;
    logic [4:0]  rega = 5'd0;
    logic [15:0] wdat = 16'd0;
    logic [1:0]  mdio_in = 2'b11;

    logic        stall_a, valid_a, err_a, mdc_a, en_a, mdo_a;
    logic        stall_b, valid_b, err_b, mdc_b, en_b, mdo_b;
    logic [15:0] rdata_a, rdata_b;

    wire [1:0] stall_w = {stall_b, stall_a};
    wire [1:0] valid_w = {valid_b, valid_a};
    wire [1:0] err_w   = {err_b, err_a};
    wire [1:0] mdc_w   = {mdc_b, mdc_a};
    wire [1:0] en_w    = {en_b, en_a};
    wire [1:0] mdo_w   = {mdo_b, mdo_a};

    int          total = 0;
    int          bad = 0;
    int          cur_row = 0;
    logic [1:0]  mdc_prev = 2'b00;
    int          ncap [2];
    logic [64:0] cap_out [2];
    logic [64:0] cap_en [2];
    logic [1:0]  phy_on = 2'b00;
    logic [15:0] phy_dat [2];
    vec_t        tbl [12];

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_stb(stb[0]), .i_c45(c45), .i_op(op),
        .i_phy_addr(phy), .i_reg_addr(rega), .i_data(wdat),
        .o_stall(stall_a), .o_valid(valid_a), .o_err(err_a), .o_data(rdata_a),
        .enet_mdc(mdc_a), .enet_mdio_en(en_a), .enet_o_mdio(mdo_a), .enet_i_mdio(mdio_in[0])
    );

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_stb(stb[1]), .i_c45(c45), .i_op(op),
        .i_phy_addr(phy), .i_reg_addr(rega), .i_data(wdat),
        .o_stall(stall_b), .o_valid(valid_b), .o_err(err_b), .o_data(rdata_b),
        .enet_mdc(mdc_b), .enet_mdio_en(en_b), .enet_o_mdio(mdo_b), .enet_i_mdio(mdio_in[1])
    );

    // PHY answer for frame bit b: TA second bit 0, then 16 data bits; otherwise released (pull-up 1).
    function automatic logic phy_bit(input int i, input int b);
        int p;
        p = (i == 0) ? 32 : 0;
        if (!phy_on[i]) return 1'b1;
        if (b == p + 15) return 1'b0;
        if (b >= p + 16 && b <= p + 31) return phy_dat[i][15 - (b - p - 16)];
        return 1'b1;
    endfunction

    // Capture MDIO at each MDC rising edge; the PHY presents its next bit right after that edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mdc_w[i] && !mdc_prev[i]) begin
                cap_out[i] = {cap_out[i][63:0], mdo_w[i]};
                cap_en[i]  = {cap_en[i][63:0], en_w[i]};
                ncap[i]    = ncap[i] + 1;
                mdio_in[i] = phy_bit(i, ncap[i]);
            end
            mdc_prev[i] = mdc_w[i];
        end
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL row%0d %s: got %0h expected %0h", cur_row, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic inst, input logic c, input logic [1:0] o,
                                input logic [4:0] p, input logic [4:0] r, input logic [15:0] wd,
                                input logic pon, input logic [15:0] pd, input logic mid,
                                input int lat, input int nbits, input logic [31:0] frame,
                                input logic [31:0] mask, input logic e, input logic [15:0] rd);
        vec_t v;
        v.inst = inst; v.c45 = c; v.op = o; v.phy = p; v.rg = r; v.wdat = wd;
        v.phy_on = pon; v.phy_dat = pd; v.mid_stb = mid;
        v.exp_lat = lat; v.exp_bits = nbits; v.exp_frame = frame; v.exp_mask = mask;
        v.exp_err = e; v.exp_rdata = rd;
        return v;
    endfunction

    // Called at a negedge; the request is sampled at the next posedge.
    task automatic run_vec(input vec_t v);
        int          i;
        int          lat;
        logic [31:0] pre;
        logic [64:0] exp_en;
        logic [64:0] exp_out;
        i = int'(v.inst);
        cap_out[i] = '0;
        cap_en[i]  = '0;
        ncap[i]    = 0;
        phy_on[i]  = v.phy_on;
        phy_dat[i] = v.phy_dat;
        mdio_in[i] = 1'b1;
        c45 = v.c45; op = v.op; phy = v.phy; rega = v.rg; wdat = v.wdat;
        stb[i] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 400 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                stb[i] = 1'b0;
                chk("stall", 65'(stall_w[i]), 65'(v.exp_lat != 1));
            end
            if (v.mid_stb && k == 100) begin
                c45 = 1'b0; op = 2'b01; phy = 5'h0A; wdat = 16'h0000;
                stb[i] = 1'b1;
            end
            if (v.mid_stb && k == 101) stb[i] = 1'b0;
            if (valid_w[i]) lat = k;
        end
        chk("latency", 65'(lat), 65'(v.exp_lat));
        chk("err", 65'(err_w[i]), 65'(v.exp_err));
        chk("rdata", 65'((i == 0) ? rdata_a : rdata_b), 65'(v.exp_rdata));
        chk("nbits", 65'(ncap[i]), 65'(v.exp_bits));
        pre     = (i == 0 && v.exp_bits != 0) ? 32'hFFFF_FFFF : 32'h0;
        exp_en  = {pre, v.exp_mask, 1'b0};
        exp_out = {pre, v.exp_frame, 1'b1};
        chk("mdio_en", cap_en[i], exp_en);
        chk("mdio_out", cap_out[i] & exp_en, exp_out & exp_en);
    endtask

    initial begin
        ncap[0] = 0; ncap[1] = 0;
        cap_out[0] = '0; cap_out[1] = '0; cap_en[0] = '0; cap_en[1] = '0;
        phy_dat[0] = 16'h0; phy_dat[1] = 16'h0;

        //          inst  c45   op     phy    reg    wdat      phy  pdat      mid   lat  bits frame          mask           err   rdata
        tbl[0]  = mk(1'b0, 1'b0, 2'b01, 5'd1,  5'd4,  16'h01E1, 1'b0, 16'h0000, 1'b0, 260, 65, 32'h5092_01E1, 32'hFFFF_FFFF, 1'b0, 16'h0000);
        tbl[1]  = mk(1'b0, 1'b0, 2'b10, 5'd3,  5'd2,  16'h0000, 1'b1, 16'h0141, 1'b0, 260, 65, 32'h6188_0000, 32'hFFFC_0000, 1'b0, 16'h0141);
        tbl[2]  = mk(1'b0, 1'b0, 2'b10, 5'd3,  5'd2,  16'h0000, 1'b0, 16'h0000, 1'b0, 260, 65, 32'h6188_0000, 32'hFFFC_0000, 1'b1, 16'hFFFF);
        tbl[3]  = mk(1'b0, 1'b0, 2'b10, 5'd0,  5'd1,  16'h0000, 1'b1, 16'h7949, 1'b1, 260, 65, 32'h6004_0000, 32'hFFFC_0000, 1'b0, 16'h7949);
        tbl[4]  = mk(1'b0, 1'b0, 2'b11, 5'd3,  5'd2,  16'h0000, 1'b0, 16'h0000, 1'b0, 1,   0,  32'h0000_0000, 32'h0000_0000, 1'b1, 16'h7949);
        tbl[5]  = mk(1'b0, 1'b0, 2'b00, 5'd3,  5'd2,  16'h0000, 1'b0, 16'h0000, 1'b0, 1,   0,  32'h0000_0000, 32'h0000_0000, 1'b1, 16'h7949);
        tbl[6]  = mk(1'b0, 1'b0, 2'b01, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 260, 65, 32'h5FFE_FFFF, 32'hFFFF_FFFF, 1'b0, 16'h7949);
        tbl[7]  = mk(1'b1, 1'b1, 2'b00, 5'd5,  5'd1,  16'h0007, 1'b0, 16'h0000, 1'b0, 132, 33, 32'h0286_0007, 32'hFFFF_FFFF, 1'b0, 16'h0000);
        tbl[8]  = mk(1'b1, 1'b1, 2'b11, 5'd5,  5'd1,  16'h0000, 1'b1, 16'hBEEF, 1'b0, 132, 33, 32'h3284_0000, 32'hFFFC_0000, 1'b0, 16'hBEEF);
        tbl[9]  = mk(1'b1, 1'b1, 2'b10, 5'd5,  5'd1,  16'h0000, 1'b1, 16'h1234, 1'b0, 132, 33, 32'h2284_0000, 32'hFFFC_0000, 1'b0, 16'h1234);
        tbl[10] = mk(1'b1, 1'b1, 2'b01, 5'd5,  5'd1,  16'hA5A5, 1'b0, 16'h0000, 1'b0, 132, 33, 32'h1286_A5A5, 32'hFFFF_FFFF, 1'b0, 16'h1234);
        tbl[11] = mk(1'b0, 1'b0, 2'b01, 5'd2,  5'd3,  16'h1234, 1'b0, 16'h0000, 1'b0, 260, 65, 32'h510E_1234, 32'hFFFF_FFFF, 1'b0, 16'h0000);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cur_row = -1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_stall", 65'(stall_w[i]), 65'(1'b0));
            chk("rst_valid", 65'(valid_w[i]), 65'(1'b0));
            chk("rst_err", 65'(err_w[i]), 65'(1'b0));
            chk("rst_data", 65'((i == 0) ? rdata_a : rdata_b), 65'(16'h0000));
            chk("rst_mdc", 65'(mdc_w[i]), 65'(1'b0));
            chk("rst_en", 65'(en_w[i]), 65'(1'b0));
            chk("rst_mdo", 65'(mdo_w[i]), 65'(1'b1));
        end

        // Each row starts in the previous row's o_valid cycle, so every request is back-to-back.
        for (int r = 0; r < 11; r++) begin
            cur_row = r;
            run_vec(tbl[r]);
        end

        // Async reset in the middle of the DATA field of a write on A.
        cur_row = 100;
        phy_on[0] = 1'b0;
        c45 = 1'b0; op = 2'b01; phy = 5'd2; rega = 5'd3; wdat = 16'h1234;
        stb[0] = 1'b1;
        @(negedge clk);
        stb[0] = 1'b0;
        repeat (219) @(negedge clk);
        chk("pre_rst_stall", 65'(stall_a), 65'(1'b1));
        chk("pre_rst_en", 65'(en_a), 65'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("arst_en", 65'(en_a), 65'(1'b0));
        chk("arst_mdc", 65'(mdc_a), 65'(1'b0));
        chk("arst_stall", 65'(stall_a), 65'(1'b0));
        chk("arst_mdo", 65'(mdo_a), 65'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        cur_row = 11;
        run_vec(tbl[11]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
